// File: rtl/decodificador_varredura.sv
// Registered N-to-2^N decoder with direct, thermometer and scan modes.
// Scan mode steps a one-hot select through all outputs via a prescaler.
module decodificador_varredura #(
  parameter int N          = 3,
  parameter int DIV        = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        modo,
  input  logic              carregar,
  input  logic [N-1:0]      sel,
  output logic [2**N-1:0]   saida,
  output logic [N-1:0]      indice,
  output logic              volta
);

  localparam int OUTS = 2**N;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]   PMAX = PW'(DIV - 1);
  localparam logic [N-1:0]    IMAX = '1;
  localparam logic [OUTS-1:0] INV  = ACTIVE_LOW ? '1 : '0;

  localparam logic [1:0] M_DIR  = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DN   = 2'b10;
  localparam logic [1:0] M_TERM = 2'b11;

  logic [PW-1:0]   presc;
  logic [PW-1:0]   presc_n;
  logic [1:0]      modo_q;
  logic [N-1:0]    idx_n;
  logic            volta_n;
  logic            scan;
  logic [OUTS-1:0] dec;

  assign scan = (modo == M_UP) || (modo == M_DN);

  // Priority: carregar > mode change > step; non-scan modes follow sel.
  always_comb begin
    idx_n   = indice;
    presc_n = presc;
    volta_n = 1'b0;
    if (!scan) begin
      idx_n   = sel;
      presc_n = '0;
    end else if (carregar) begin
      idx_n   = sel;
      presc_n = '0;
    end else if (modo != modo_q) begin
      presc_n = '0;
    end else if (presc == PMAX) begin
      presc_n = '0;
      if (modo == M_UP) begin
        idx_n   = indice + 1'b1;
        volta_n = (indice == IMAX);
      end else begin
        idx_n   = indice - 1'b1;
        volta_n = (indice == '0);
      end
    end else begin
      presc_n = presc + 1'b1;
    end
  end

  always_comb begin
    dec = '0;
    for (int i = 0; i < OUTS; i++) begin
      if (modo == M_TERM)
        dec[i] = (N'(i) <= idx_n);
      else
        dec[i] = (N'(i) == idx_n);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      saida  <= INV;
      indice <= '0;
      volta  <= 1'b0;
      presc  <= '0;
      modo_q <= modo;
    end else if (!en) begin
      saida  <= INV;
      volta  <= 1'b0;
    end else begin
      saida  <= dec ^ INV;
      indice <= idx_n;
      volta  <= volta_n;
      presc  <= presc_n;
      modo_q <= modo;
    end
  end

  logic unused_dir;
  assign unused_dir = (M_DIR == 2'b00);

endmodule

// File: doc/decodificador_varredura.md
Name: decodificador_varredura

Overview:
Parametrised, registered N-to-2^N decoder; successor of the fixed 3-to-8 combinational decoder. Adds enable, selectable output polarity, thermometer mode and an autonomous scan sequencer. The scan sequencer has a prescaler and up/down stepping, so the block can drive multiplexed display digits or LED rows directly. It sits between control logic and output drivers, and also replaces the plain decoder wherever a registered one-hot select is needed.

Parameters:
N, 3, select width; output count OUTS = 2**N (N >= 1)
DIV, 4, scan prescaler period in clocks (DIV >= 1; DIV = 1 steps every cycle)
ACTIVE_LOW, 0, 1 = every bit of saida inverted at the output register

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
en  in  1  enable; 0 = outputs inactive, all state frozen
modo  in  2  00 direct, 01 scan up, 10 scan down, 11 thermometer
carregar  in  1  scan modes only: load scan index from sel
sel  in  N  select value (direct/thermometer) or load value (scan)
saida  out  2**N  decoded output, registered
indice  out  N  currently decoded index, registered
volta  out  1  one-cycle pulse on scan wrap-around

Behaviour:
- Clock and reset:
  - One clock (clk).
  - Reset (rst) is synchronous and active-high; it has priority over every other input.
- Reset values:
  - saida = all inactive (0s, or all 1s if ACTIVE_LOW).
  - indice = 0, volta = 0, prescaler = 0.
- Output encoding and latency:
  - "Active" below means logical 1 before polarity inversion.
  - All outputs are registered: inputs sampled at edge k appear after edge k (1-cycle latency).
  - saida always equals decode(indice, modo), except when en = 0.
- en = 0:
  - saida is driven all inactive; volta = 0.
  - indice and the prescaler hold their values.
- modo 00 (direct):
  - indice <= sel; saida is one-hot at bit sel.
  - Prescaler is cleared; volta = 0.
- modo 11 (thermometer):
  - indice <= sel; saida bits [sel:0] active, all higher bits inactive.
  - Prescaler is cleared; volta = 0.
- modo 01 / 10 (scan):
  - Free-running prescaler counts 0..DIV-1.
  - When the prescaler = DIV-1: prescaler <= 0 and indice steps +1 (01) or -1 (10), modulo OUTS.
  - Otherwise indice holds.
  - saida is one-hot at the new indice in the same register update.
- volta:
  - Asserted for exactly one cycle, concurrent with the saida update, on wrap-around only.
  - Up wrap: OUTS-1 -> 0. Down wrap: 0 -> OUTS-1.
- carregar = 1 in a scan mode:
  - indice <= sel and prescaler <= 0; volta = 0.
  - carregar has priority over a step in the same cycle.
  - carregar is ignored in modes 00 and 11.
- Mode change:
  - Any change of modo clears the prescaler that cycle.
  - Scan resumes from the current indice; there is no step in the change cycle.
  - The first step comes DIV cycles later.
- Simultaneous events: priority is rst > en = 0 > carregar > mode change > step.
- Reset mid-scan: the next cycle shows reset values; scan restarts from index 0 with a full DIV period.
- Arithmetic:
  - Index arithmetic is N-bit unsigned with natural wrap.
  - Prescaler width is clog2(DIV), minimum 1 bit.

Test Plan:
- Reset, then direct decode (N=3, en=1, modo=00), sel swept 0..7 -> saida = 00000001..10000000, one cycle after each sel; indice = sel; volta never set.
- Scan up (N=3, DIV=4) from reset, 40 cycles -> indice steps every 4 cycles 0,1,...,7,0; volta pulses high exactly 1 cycle when indice goes 7 -> 0; saida one-hot tracks indice.
- Scan down (DIV=1) from indice=2 -> indice 1,0,7,6 on consecutive cycles; volta high only on the 0 -> 7 cycle.
- Load and enable gating in scan up (DIV=4):
  - carregar=1, sel=5 on the same cycle a step is due -> indice=5, no step, next step 4 cycles later.
  - en=0 for 6 cycles -> saida = 0 and indice frozen; resumes at the same index with the same prescaler phase.
- Thermometer and polarity:
  - modo=11, sel=5 -> saida = 00111111.
  - Same stimulus with ACTIVE_LOW=1 -> saida = 11000000.
  - ACTIVE_LOW=1 after reset -> saida = 11111111.
- Reset mid-scan: rst=1 for 1 cycle while indice=6, with a step due the same cycle -> indice = 0, saida inactive, volta = 0; first step occurs DIV cycles after rst drops.
